time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
- Timekeeping datapath that sits directly downstream of the clock-mode state machine.
- Counts seconds, minutes and hours in packed BCD from a 1 Hz enable pulse.
- Applies the state machine's adjustment commands (sec_reset, min_inc, hour_inc).
- Turns its per-field select flags (sec_onoff, min_onoff, hour_onoff) into blink-blanking signals for the display driver.

Parameters:
- HOUR_MOD, 24, hour modulus; legal values 24 (hours 00-23) or 12 (hours 00-11). Any other value is a synthesis error.

Ports:
- ck  input  1  system clock; all state changes on the rising edge.
- sysreset  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-ck-wide timebase pulse; advances time by one second.
- blink_tick  input  1  one-ck-wide pulse; toggles the blink phase.
- sec_reset  input  1  clear seconds (from the mode FSM).
- min_inc  input  1  add one minute (from the mode FSM).
- hour_inc  input  1  add one hour (from the mode FSM).
- sec_onoff  input  1  seconds field selected for setting.
- min_onoff  input  1  minutes field selected for setting.
- hour_onoff  input  1  hours field selected for setting.
- sec_bcd  output  8  seconds, [7:4] tens, [3:0] units, range 00-59.
- min_bcd  output  8  minutes, range 00-59.
- hour_bcd  output  8  hours, range 00-(HOUR_MOD-1).
- sec_blank  output  1  display must blank the seconds digits.
- min_blank  output  1  display must blank the minutes digits.
- hour_blank  output  1  display must blank the hours digits.
- day_carry  output  1  one-ck pulse when hours wrap via the tick path.

Behaviour:
- Reset: when sysreset is high at a rising edge, all BCD fields become 00, blink_phase 0 and day_carry 0. sysreset overrides every other input that cycle.
- All outputs are registered. One cycle of latency from any input pulse to the visible change.
- BCD arithmetic:
  - Units count 0-9. Tens increment when units wrap 9->0.
  - Seconds and minutes wrap 59->00.
  - Hours wrap 23->00 (HOUR_MOD=24) or 11->00 (HOUR_MOD=12).
  - Non-BCD values are never produced.
- Tick path: applies only when tick_1hz=1 and sec_reset, min_inc and hour_inc are all 0.
  - Seconds +1.
  - On seconds wrap, minutes +1.
  - On minutes wrap, hours +1.
  - On hours wrap, day_carry=1 for exactly that cycle.
- Adjustment path: when any of sec_reset, min_inc or hour_inc is 1, tick_1hz is ignored for that cycle. The tick is dropped, not deferred.
  - sec_reset: seconds <= 00. Minutes and hours unchanged, no carry.
  - min_inc: minutes +1 mod 60. Never carries into hours.
  - hour_inc: hours +1 mod HOUR_MOD. day_carry stays 0.
  - When several adjustment inputs are high together, each applies to its own field in the same cycle.
- Level adjustment inputs advance once per cycle while held. Upstream is responsible for delivering single-cycle pulses.
- Blink:
  - blink_phase is a flop.
  - While all three onoff inputs are 0, it is forced to 0.
  - Otherwise it toggles on each blink_tick.
  - sec_blank = sec_onoff & blink_phase, registered. min_blank and hour_blank are formed the same way.
  - Entering a setting mode therefore starts with the digits visible. The first blank appears one cycle after the first blink_tick.
- The onoff inputs are at most one-hot from the FSM. The block must still be well defined if several are high: each drives its own blank.
- Reset mid-count or mid-blink takes effect on the next edge with no residual pulses.

Test Plan:
1. Reset then 61 tick_1hz pulses -> sec_bcd=8'h01 and min_bcd=8'h01. sec_bcd reads 8'h59 just before the 60th tick and 8'h00 after it.
2. Preload 23:59:59 by adjustment pulses, then one tick -> 00:00:00 and a one-cycle day_carry. Rerun with HOUR_MOD=12 from 11:59:59 -> 00:00:00.
3. min_inc at min=59, hour=05 -> min=00, hour=05, day_carry=0. hour_inc at 23 -> 00 with no day_carry.
4. tick_1hz together with sec_reset at sec=42 -> sec=00. Tick together with min_inc at 10:20:59 -> 10:21:59; the tick is dropped.
5. hour_onoff=1 with blink_tick every 4 cycles -> hour_blank toggles 0,1,0,…, changing one cycle after each tick. min_blank and sec_blank stay 0. Dropping hour_onoff gives all blanks 0 next cycle.
6. sysreset asserted during a tick, or during a blank=1 phase -> all fields 00, blanks 0 and day_carry 0 on the next edge.

Source files
------------

// File: rtl/time_counter_if.sv
// Bundle between the clock-mode state machine, the time counter and the display driver.
// The controller side uses the master modport and the counter uses the slave modport.
interface time_counter_if;
   logic       tick_1hz;
   logic       blink_tick;
   logic       sec_reset;
   logic       min_inc;
   logic       hour_inc;
   logic       sec_onoff;
   logic       min_onoff;
   logic       hour_onoff;
   logic [7:0] sec_bcd;
   logic [7:0] min_bcd;
   logic [7:0] hour_bcd;
   logic       sec_blank;
   logic       min_blank;
   logic       hour_blank;
   logic       day_carry;

   modport master (
      output tick_1hz, blink_tick, sec_reset, min_inc, hour_inc,
      output sec_onoff, min_onoff, hour_onoff,
      input  sec_bcd, min_bcd, hour_bcd,
      input  sec_blank, min_blank, hour_blank, day_carry
   );

   modport slave (
      input  tick_1hz, blink_tick, sec_reset, min_inc, hour_inc,
      input  sec_onoff, min_onoff, hour_onoff,
      output sec_bcd, min_bcd, hour_bcd,
      output sec_blank, min_blank, hour_blank, day_carry
   );
endinterface

// File: rtl/time_counter.sv
// Packed-BCD seconds/minutes/hours counter with set-mode adjustments and blink blanking.
// Every output comes straight from a flop.
module time_counter #(
   parameter int HOUR_MOD = 24
) (
   input  logic          ck_i,
   input  logic          sysreset_i,
   time_counter_if.slave tc_bus
);

   generate
      if (HOUR_MOD != 24 && HOUR_MOD != 12) begin : g_bad_hour_mod
         $error("time_counter: HOUR_MOD must be 24 or 12");
      end
   endgenerate

   localparam logic [7:0] HOUR_MAX = (HOUR_MOD == 12) ? 8'h11 : 8'h23;

   // Wraps to 00 at max_v; otherwise a BCD +1 with units carry into tens.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
      logic [7:0] r;
      if (v == max_v) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   logic [7:0] sec_q,  sec_d;
   logic [7:0] min_q,  min_d;
   logic [7:0] hour_q, hour_d;
   logic       carry_q, carry_d;
   logic       phase_q, phase_d;
   logic [2:0] blank_q, blank_d;

   logic adj_w;
   logic tick_w;
   logic sec_wrap_w;
   logic min_wrap_w;
   logic hour_wrap_w;
   logic any_sel_w;

   always_comb begin
      adj_w       = tc_bus.sec_reset | tc_bus.min_inc | tc_bus.hour_inc;
      // A tick coinciding with any adjustment is dropped, not deferred.
      tick_w      = tc_bus.tick_1hz & ~adj_w;
      sec_wrap_w  = tick_w & (sec_q == 8'h59);
      min_wrap_w  = sec_wrap_w & (min_q == 8'h59);
      hour_wrap_w = min_wrap_w & (hour_q == HOUR_MAX);

      sec_d = sec_q;
      if (tc_bus.sec_reset) begin
         sec_d = 8'h00;
      end else if (tick_w) begin
         sec_d = bcd_inc(sec_q, 8'h59);
      end

      min_d = min_q;
      if (tc_bus.min_inc || min_wrap_w || sec_wrap_w) begin
         min_d = bcd_inc(min_q, 8'h59);
      end

      hour_d = hour_q;
      if (tc_bus.hour_inc || min_wrap_w) begin
         hour_d = bcd_inc(hour_q, HOUR_MAX);
      end

      carry_d = hour_wrap_w;

      any_sel_w = tc_bus.sec_onoff | tc_bus.min_onoff | tc_bus.hour_onoff;
      phase_d   = phase_q;
      if (!any_sel_w) begin
         phase_d = 1'b0;
      end else if (tc_bus.blink_tick) begin
         phase_d = ~phase_q;
      end

      blank_d = {tc_bus.hour_onoff, tc_bus.min_onoff, tc_bus.sec_onoff} & {3{phase_q}};
   end

   always_ff @(posedge ck_i) begin
      if (sysreset_i) begin
         sec_q   <= 8'h00;
         min_q   <= 8'h00;
         hour_q  <= 8'h00;
         carry_q <= 1'b0;
         phase_q <= 1'b0;
         blank_q <= 3'b000;
      end else begin
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         carry_q <= carry_d;
         phase_q <= phase_d;
         blank_q <= blank_d;
      end
   end

   assign tc_bus.sec_bcd    = sec_q;
   assign tc_bus.min_bcd    = min_q;
   assign tc_bus.hour_bcd   = hour_q;
   assign tc_bus.day_carry  = carry_q;
   assign tc_bus.sec_blank  = blank_q[0];
   assign tc_bus.min_blank  = blank_q[1];
   assign tc_bus.hour_blank = blank_q[2];

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a 24-hour and a 12-hour instance share stimulus and are
// checked against a seconds-of-day reference model, a vector table and corner sequences.
module tb_time_counter;

   typedef struct packed {
      logic rst;
      logic tick;
      logic blink;
      logic sr;
      logic mi;
      logic hi;
      logic so;
      logic mo;
      logic ho;
   } in_t;

   typedef struct {
      in_t        in;
      logic [7:0] es;
      logic [7:0] em;
      logic [7:0] eh;
      logic       ec;
      logic [2:0] eb;
   } vec_t;

   logic ck = 1'b0;
   logic sysreset;
   always #5 ck = ~ck;

   time_counter_if bus24 ();
   time_counter_if bus12 ();

   time_counter #(.HOUR_MOD(24)) dut24 (.ck_i(ck), .sysreset_i(sysreset), .tc_bus(bus24.slave));
   time_counter #(.HOUR_MOD(12)) dut12 (.ck_i(ck), .sysreset_i(sysreset), .tc_bus(bus12.slave));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain integers, time advanced as seconds-of-day.
   int       ms [2];
   int       mm [2];
   int       mh [2];
   bit       mc [2];
   int       hmod [2] = '{24, 12};
   bit       ph;
   bit [2:0] blk;

   function automatic in_t mk(bit rst, bit tick, bit blink, bit sr, bit mi, bit hi,
                              bit so, bit mo, bit ho);
      in_t v;
      v.rst = rst; v.tick = tick; v.blink = blink;
      v.sr = sr; v.mi = mi; v.hi = hi;
      v.so = so; v.mo = mo; v.ho = ho;
      return v;
   endfunction

   function automatic logic [7:0] to_bcd(int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(in_t v);
      sysreset         = v.rst;
      bus24.tick_1hz   = v.tick;  bus12.tick_1hz   = v.tick;
      bus24.blink_tick = v.blink; bus12.blink_tick = v.blink;
      bus24.sec_reset  = v.sr;    bus12.sec_reset  = v.sr;
      bus24.min_inc    = v.mi;    bus12.min_inc    = v.mi;
      bus24.hour_inc   = v.hi;    bus12.hour_inc   = v.hi;
      bus24.sec_onoff  = v.so;    bus12.sec_onoff  = v.so;
      bus24.min_onoff  = v.mo;    bus12.min_onoff  = v.mo;
      bus24.hour_onoff = v.ho;    bus12.hour_onoff = v.ho;
   endtask

   task automatic model_step(in_t v);
      int t;
      for (int d = 0; d < 2; d++) begin
         mc[d] = 1'b0;
         if (v.rst) begin
            ms[d] = 0; mm[d] = 0; mh[d] = 0;
         end else begin
            if (v.sr) ms[d] = 0;
            if (v.mi) mm[d] = (mm[d] + 1) % 60;
            if (v.hi) mh[d] = (mh[d] + 1) % hmod[d];
            if (v.tick && !(v.sr || v.mi || v.hi)) begin
               t = ms[d] + 60 * mm[d] + 3600 * mh[d] + 1;
               if (t == hmod[d] * 3600) begin
                  t = 0;
                  mc[d] = 1'b1;
               end
               ms[d] = t % 60;
               mm[d] = (t / 60) % 60;
               mh[d] = t / 3600;
            end
         end
      end
      if (v.rst) begin
         blk = 3'b000;
         ph  = 1'b0;
      end else begin
         blk = {v.ho, v.mo, v.so} & {3{ph}};
         if (!(v.so || v.mo || v.ho)) ph = 1'b0;
         else if (v.blink)            ph = ~ph;
      end
   endtask

   task automatic check_model();
      chk("m24_sec",   bus24.sec_bcd,  to_bcd(ms[0]));
      chk("m24_min",   bus24.min_bcd,  to_bcd(mm[0]));
      chk("m24_hour",  bus24.hour_bcd, to_bcd(mh[0]));
      chk("m24_carry", 8'(bus24.day_carry), 8'(mc[0]));
      chk("m24_blank", 8'({bus24.hour_blank, bus24.min_blank, bus24.sec_blank}), 8'(blk));
      chk("m12_sec",   bus12.sec_bcd,  to_bcd(ms[1]));
      chk("m12_min",   bus12.min_bcd,  to_bcd(mm[1]));
      chk("m12_hour",  bus12.hour_bcd, to_bcd(mh[1]));
      chk("m12_carry", 8'(bus12.day_carry), 8'(mc[1]));
      chk("m12_blank", 8'({bus12.hour_blank, bus12.min_blank, bus12.sec_blank}), 8'(blk));
   endtask

   task automatic step(in_t v);
      drive(v);
      @(posedge ck);
      model_step(v);
      #1;
      check_model();
   endtask

   // One active cycle followed by one idle cycle, keeping pulses one ck wide.
   task automatic pulse(in_t v);
      step(v);
      step(mk(0, 0, 0, 0, 0, 0, v.so, v.mo, v.ho));
   endtask

   task automatic preload(int h, int m, int s);
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < h; i++) pulse(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      for (int i = 0; i < m; i++) pulse(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      for (int i = 0; i < s; i++) pulse(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
   endtask

   vec_t vecs [16];
   in_t  idle;
   in_t  rv;

   initial begin
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[0]  = '{mk(1,0,0,0,0,0,0,0,0), 8'h00, 8'h00, 8'h00, 1'b0, 3'b000};
      vecs[1]  = '{mk(0,1,0,0,0,0,0,0,0), 8'h01, 8'h00, 8'h00, 1'b0, 3'b000};
      vecs[2]  = '{mk(0,0,0,0,1,0,0,0,0), 8'h01, 8'h01, 8'h00, 1'b0, 3'b000};
      vecs[3]  = '{mk(0,0,0,0,0,1,0,0,0), 8'h01, 8'h01, 8'h01, 1'b0, 3'b000};
      vecs[4]  = '{mk(0,1,0,1,0,0,0,0,0), 8'h00, 8'h01, 8'h01, 1'b0, 3'b000};
      vecs[5]  = '{mk(0,0,0,1,1,1,0,0,0), 8'h00, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[6]  = '{mk(0,1,0,0,0,0,0,0,0), 8'h01, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[7]  = '{mk(0,0,0,0,0,0,0,0,1), 8'h01, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[8]  = '{mk(0,0,1,0,0,0,0,0,1), 8'h01, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[9]  = '{mk(0,0,0,0,0,0,0,0,1), 8'h01, 8'h02, 8'h02, 1'b0, 3'b100};
      vecs[10] = '{mk(0,0,1,0,0,0,1,0,0), 8'h01, 8'h02, 8'h02, 1'b0, 3'b001};
      vecs[11] = '{mk(0,0,0,0,0,0,1,0,0), 8'h01, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[12] = '{mk(0,0,0,0,0,0,0,0,0), 8'h01, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[13] = '{mk(0,0,1,0,0,0,1,1,0), 8'h01, 8'h02, 8'h02, 1'b0, 3'b000};
      vecs[14] = '{mk(0,1,0,0,0,0,1,1,0), 8'h02, 8'h02, 8'h02, 1'b0, 3'b011};
      vecs[15] = '{mk(1,1,1,0,0,0,1,1,1), 8'h00, 8'h00, 8'h00, 1'b0, 3'b000};

      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      ms = '{0, 0}; mm = '{0, 0}; mh = '{0, 0}; mc = '{0, 0}; ph = 0; blk = 0;
      @(negedge ck);

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].in);
         chk($sformatf("vec%0d_sec", i),   bus24.sec_bcd,  vecs[i].es);
         chk($sformatf("vec%0d_min", i),   bus24.min_bcd,  vecs[i].em);
         chk($sformatf("vec%0d_hour", i),  bus24.hour_bcd, vecs[i].eh);
         chk($sformatf("vec%0d_carry", i), 8'(bus24.day_carry), 8'(vecs[i].ec));
         chk($sformatf("vec%0d_blank", i),
             8'({bus24.hour_blank, bus24.min_blank, bus24.sec_blank}), 8'(vecs[i].eb));
      end

      // 61 ticks from reset
      preload(0, 0, 59);
      chk("t1_sec_before60", bus24.sec_bcd, 8'h59);
      chk("t1_min_before60", bus24.min_bcd, 8'h00);
      step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      chk("t1_sec_after60", bus24.sec_bcd, 8'h00);
      chk("t1_min_after60", bus24.min_bcd, 8'h01);
      step(idle);
      pulse(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      chk("t1_sec_61", bus24.sec_bcd, 8'h01);
      chk("t1_min_61", bus24.min_bcd, 8'h01);

      // day wrap: 23 hour_inc leaves the 12-hour instance at 11
      preload(23, 59, 59);
      chk("t2_h24_pre", bus24.hour_bcd, 8'h23);
      chk("t2_h12_pre", bus12.hour_bcd, 8'h11);
      step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
      chk("t2_h24_wrap", {bus24.hour_bcd[3:0], bus24.min_bcd[3:0]} | bus24.sec_bcd, 8'h00);
      chk("t2_carry24", 8'(bus24.day_carry), 8'h01);
      chk("t2_h12_wrap", {bus12.hour_bcd[3:0], bus12.min_bcd[3:0]} | bus12.sec_bcd, 8'h00);
      chk("t2_carry12", 8'(bus12.day_carry), 8'h01);
      step(idle);
      chk("t2_carry24_gone", 8'(bus24.day_carry), 8'h00);
      chk("t2_carry12_gone", 8'(bus12.day_carry), 8'h00);

      // min_inc at 59 never carries; hour_inc at 23 has no day_carry
      preload(5, 59, 0);
      step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      chk("t3_min_wrap", bus24.min_bcd, 8'h00);
      chk("t3_hour_kept", bus24.hour_bcd, 8'h05);
      chk("t3_no_carry", 8'(bus24.day_carry), 8'h00);
      for (int i = 0; i < 18; i++) pulse(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      chk("t3_hour_wrap", bus24.hour_bcd, 8'h00);
      chk("t3_hour_no_carry", 8'(bus24.day_carry), 8'h00);

      // tick dropped when coinciding with an adjustment
      preload(0, 0, 42);
      step(mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
      chk("t4_sec_reset", bus24.sec_bcd, 8'h00);
      preload(10, 20, 59);
      step(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
      chk("t4_sec_kept", bus24.sec_bcd, 8'h59);
      chk("t4_min_inc", bus24.min_bcd, 8'h21);
      chk("t4_hour_kept", bus24.hour_bcd, 8'h10);

      // hour blink with blink_tick every 4 cycles
      step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int p = 0; p < 4; p++) begin
         step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
         chk("t5_blank_hold", 8'(bus24.hour_blank), 8'(p % 2));
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
         chk("t5_blank_toggle", 8'(bus24.hour_blank), 8'((p % 2) == 0));
         chk("t5_other_blank", 8'({bus24.min_blank, bus24.sec_blank}), 8'h00);
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
      step(mk(0, 0, 1, 0, 0, 0, 0, 0, 1));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      chk("t5_blank_on", 8'(bus24.hour_blank), 8'h01);
      step(idle);
      chk("t5_drop_onoff", 8'({bus24.hour_blank, bus24.min_blank, bus24.sec_blank}), 8'h00);

      // reset during a tick, during blanking and on a carry cycle
      preload(3, 4, 5);
      step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      chk("t6_rst_tick", bus24.sec_bcd | bus24.min_bcd | bus24.hour_bcd, 8'h00);
      step(mk(0, 0, 1, 0, 0, 0, 1, 1, 1));
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
      chk("t6_blank_set", 8'({bus24.hour_blank, bus24.min_blank, bus24.sec_blank}), 8'h07);
      step(mk(1, 0, 0, 0, 0, 0, 1, 1, 1));
      chk("t6_rst_blank", 8'({bus24.hour_blank, bus24.min_blank, bus24.sec_blank}), 8'h00);
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
      chk("t6_no_residual", 8'({bus24.hour_blank, bus24.min_blank, bus24.sec_blank}), 8'h00);
      preload(23, 59, 59);
      step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      chk("t6_rst_carry", 8'(bus24.day_carry), 8'h00);
      chk("t6_rst_hour", bus24.hour_bcd, 8'h00);

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rv.rst   = ($urandom_range(0, 127) == 0);
         rv.tick  = ($urandom_range(0, 1) == 0);
         rv.blink = ($urandom_range(0, 3) == 0);
         rv.sr    = ($urandom_range(0, 15) == 0);
         rv.mi    = ($urandom_range(0, 7) == 0);
         rv.hi    = ($urandom_range(0, 7) == 0);
         rv.so    = ($urandom_range(0, 3) == 0);
         rv.mo    = ($urandom_range(0, 3) == 0);
         rv.ho    = ($urandom_range(0, 3) == 0);
         step(rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
